mul_job_sequencer: RTL and testbench
====================================

Name: mul_job_sequencer

Overview:
- Upstream/downstream control stage wrapped around the N-bit shift-add integer multiplier.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one job at a time using the multiplier's start/done protocol, and holds operands stable for the whole job.
- Captures the single-cycle product and presents it on a valid/ready result stream. Includes a watchdog timeout and a job counter.

Parameters:
N, 4, operand width; must match the attached multiplier.
DEPTH, 4, operand FIFO entries; power of 2, >= 2.
TIMEOUT, 4*N+8, max cycles in S_WAIT before the watchdog fires.

Ports:
clock  in  1  clock; all state updates on rising edge
reset  in  1  reset, asynchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (count < DEPTH)
in_multiplicand  in  N  operand A
in_multiplier  in  N  operand B
out_valid  out  1  result register holds an unconsumed product
out_ready  in  1  consumer accepts result
out_product  out  2N+1  registered product
mul_start  out  1  one-cycle start pulse to multiplier
mul_multiplicand  out  N  registered operand A to multiplier
mul_multiplier  out  N  registered operand B to multiplier
mul_done  in  1  multiplier done pulse (1 cycle)
mul_product  in  2N+1  multiplier product, valid only while mul_done=1
busy  out  1  state != S_IDLE or FIFO non-empty
timeout_err  out  1  sticky watchdog flag
jobs_done  out  16  count of products captured, wraps at 2^16

Behaviour:
- Reset (async): all outputs 0; FIFO empty; state S_IDLE; operand regs 0; timeout counter 0.
- Push: occurs at an edge when in_valid && in_ready. in_ready = (count < DEPTH). No push when full, even if a pop happens in the same cycle.
- FIFO: count may change by -1, 0 or +1 per cycle. Simultaneous push and pop (not full) leaves count unchanged. Pointers wrap modulo DEPTH.
- Result push/pop: out_valid clears at an edge when out_valid && out_ready. out_product stays unchanged while out_valid=1.
- FSM states: S_IDLE, S_START, S_WAIT.
  - S_IDLE: if FIFO non-empty and out_valid=0, then pop the head into mul_multiplicand/mul_multiplier and go to S_START. Otherwise stay.
  - S_START: mul_start=1 (combinational from state, exactly one cycle); clear watchdog counter; go to S_WAIT.
  - S_WAIT:
    - If mul_done=1: out_product <= mul_product; out_valid <= 1; jobs_done <= jobs_done+1; go to S_IDLE.
    - Else increment watchdog. When it reaches TIMEOUT: timeout_err <= 1; out_valid stays 0; job dropped; go to S_IDLE.
- Operand regs change only on a pop. They are therefore stable from mul_start until mul_done, as the multiplier requires (it samples the multiplicand every TEST cycle).
- Job gap: the earliest next mul_start is 2 cycles after the mul_done edge, so the multiplier is back in IDLE.
- A new job never issues while out_valid=1. Backpressure on out_ready stalls the pipeline; no result is ever overwritten.
- Job-complete and result-consume in the same cycle: legal when the result drains in S_IDLE. Capture cannot coincide, since a capture requires out_valid=0 at issue.
- mul_done outside S_WAIT: ignored (no capture, no count).
- mul_product passes through unmodified (2N+1 bits; MSB is 0 for all valid products).
- Watchdog: timeout_err clears only on reset.
- Reset mid-job: async clear of everything. The multiplier shares the same reset, so no stale done arrives.
- Latency (empty FIFO, out_valid=0): push at edge t → pop t+1 → mul_start high in cycle t+1..t+2 → out_valid = (mul_done edge)+1.

Test Plan:
1. N=4: push A=13, B=11 with a behavioural multiplier model → exactly one mul_start pulse; out_product=143 (0x08F); jobs_done=1; in_ready stays 1.
2. Push 15×15, 0×9, 1×1 back-to-back with out_ready=1 → results 225, 0, 1 in order; each mul_start ≥2 cycles after the prior mul_done; jobs_done=3.
3. Hold out_ready=0 and push 5 pairs → first result held, no further mul_start; count=4 and in_ready=0 after 4 buffered. Release out_ready → remaining 4 results drain in order.
4. Tie mul_done=0 and push 3×3 → after TIMEOUT (24) S_WAIT cycles timeout_err=1, out_valid=0, next job issues; timeout_err stays 1 until reset.
5. Assert reset during S_WAIT with 2 jobs queued → all outputs 0 and in_ready=1 immediately; no mul_start until a new push.
6. Pulse mul_done while in S_IDLE with mul_product=0x1FF → out_valid stays 0; jobs_done unchanged.

Source files
------------

// File: rtl/mul_job_sequencer.sv
// mul_job_sequencer: queues operand pairs and runs them one at a time through the shift-add multiplier.
// Latency: push to mul_start is 1-2 cycles (empty FIFO); out_valid rises one cycle after mul_done.
// Backpressure: in_ready drops while the FIFO is full; no job issues while a result is unconsumed.
// Ports: in_* operand stream (valid/ready), out_* result stream (valid/ready),
//        mul_* start/done handshake to the multiplier, busy/timeout_err/jobs_done status.
module mul_job_sequencer #(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4*N+8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_multiplicand,
    input  logic [N-1:0]   in_multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N:0]   out_product,
    output logic           mul_start,
    output logic [N-1:0]   mul_multiplicand,
    output logic [N-1:0]   mul_multiplier,
    input  logic           mul_done,
    input  logic [2*N:0]   mul_product,
    output logic           busy,
    output logic           timeout_err,
    output logic [15:0]    jobs_done
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [N-1:0] multiplicand;
        logic [N-1:0] multiplier;
    } job_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    job_t              fifo_mem [DEPTH];
    job_t              in_job;
    job_t              head_job;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic              do_push, pop_job;
    logic              capture, fire_timeout, wd_inc;
    logic [WD_W-1:0]   wd_cnt;

    // ---------------------------------------------------------------
    // Operand FIFO. A push is refused whenever full, even if a pop
    // frees a slot at the same edge, so in_ready is purely registered.
    // ---------------------------------------------------------------
    assign in_job     = '{multiplicand: in_multiplicand, multiplier: in_multiplier};
    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = !fifo_full;
    assign do_push    = in_valid && !fifo_full;
    assign head_job   = fifo_mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_job) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop_job})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) fifo_mem[wr_ptr] <= in_job;
    end

    // ---------------------------------------------------------------
    // Job FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pop_job      = 1'b0;
        mul_start    = 1'b0;
        capture      = 1'b0;
        fire_timeout = 1'b0;
        wd_inc       = 1'b0;
        case (state)
            S_IDLE: begin
                // Holding off while out_valid is set guarantees a capture
                // can never land on an unconsumed result.
                if (!fifo_empty && !out_valid) begin
                    pop_job   = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                mul_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    capture   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wd_inc = 1'b1;
                    // This cycle is the TIMEOUT-th consecutive one without done.
                    if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        fire_timeout = 1'b1;
                        state_nxt    = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Operand registers, result register, watchdog and status.
    // Operands only move on a pop, so they stay put for the whole job.
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            jobs_done        <= '0;
            timeout_err      <= 1'b0;
            wd_cnt           <= '0;
        end else begin
            if (pop_job) begin
                mul_multiplicand <= head_job.multiplicand;
                mul_multiplier   <= head_job.multiplier;
            end

            if (capture) begin
                out_product <= mul_product;
                out_valid   <= 1'b1;
                jobs_done   <= jobs_done + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (mul_start)   wd_cnt <= '0;
            else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;

            if (fire_timeout) timeout_err <= 1'b1;
        end
    end

    assign busy = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_job_sequencer.sv
// tb_mul_job_sequencer: directed bench for mul_job_sequencer with a behavioural multiplier.
// Latency: the multiplier model answers MODEL_LAT cycles after sampling mul_start.
// Backpressure: out_ready is driven per scenario to exercise result stalls.
module tb_mul_job_sequencer;
    localparam int N         = 4;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 24;
    localparam int MODEL_LAT = 6;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_multiplicand;
    logic [N-1:0] in_multiplier;
    logic         out_valid;
    logic         out_ready;
    logic [2*N:0] out_product;
    logic         mul_start;
    logic [N-1:0] mul_multiplicand;
    logic [N-1:0] mul_multiplier;
    logic         mul_done;
    logic [2*N:0] mul_product;
    logic         busy;
    logic         timeout_err;
    logic [15:0]  jobs_done;

    // multiplier model and injection controls
    logic         model_en;
    logic         model_done;
    logic [2*N:0] model_product;
    logic         inj_done;
    logic [2*N:0] inj_product;
    logic         m_busy;
    int           m_cnt;
    logic [N-1:0] m_a, m_b;

    // monitor state
    int           cyc = 0;
    int           start_count = 0;
    int           start_cyc = -1;
    int           done_cyc = -1;
    int           push_cyc = -1;
    int           res_cyc = -1;
    int           min_gap = 1000;
    int           operand_unstable = 0;
    logic [2*N:0] results [$];

    int           checks = 0;
    int           errors = 0;

    assign mul_done    = (model_done && model_en) || inj_done;
    assign mul_product = inj_done ? inj_product : model_product;

    mul_job_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_done         (mul_done),
        .mul_product      (mul_product),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .jobs_done        (jobs_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Behavioural multiplier plus stream monitor, all sampled at the edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            model_done    <= 1'b0;
            model_product <= '0;
        end else begin
            model_done <= 1'b0;
            if (mul_done) done_cyc = cyc;
            if (mul_start) begin
                start_count++;
                start_cyc = cyc;
                if (done_cyc >= 0 && (cyc - done_cyc) < min_gap) min_gap = cyc - done_cyc;
                m_busy = 1'b1;
                m_cnt  = 0;
                m_a    = mul_multiplicand;
                m_b    = mul_multiplier;
            end else if (m_busy) begin
                if (mul_multiplicand !== m_a || mul_multiplier !== m_b) operand_unstable++;
                m_cnt++;
                if (m_cnt == MODEL_LAT) begin
                    model_done    <= 1'b1;
                    model_product <= 9'(m_a) * 9'(m_b);
                    m_busy = 1'b0;
                end
            end
            if (in_valid && in_ready) push_cyc = cyc;
            if (out_valid && out_ready) begin
                results.push_back(out_product);
                res_cyc = cyc;
            end
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
        int k = 0;
        in_valid        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        while (!in_ready && k < 500) begin
            @(negedge clock);
            k++;
        end
        if (!in_ready) check("push_accept", 0, 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string tag);
        int k = 0;
        while (results.size() < n && k < 500) begin
            @(negedge clock);
            k++;
        end
        check(tag, results.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || out_valid) && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("wait_idle", {31'd0, busy || out_valid}, 0);
    endtask

    initial begin
        int s0;
        int n;
        reset           = 1'b1;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        out_ready       = 1'b1;
        model_en        = 1'b1;
        inj_done        = 1'b0;
        inj_product     = '0;

        // ---- reset state ----
        repeat (2) @(negedge clock);
        check("rst_out_valid",   out_valid, 0);
        check("rst_out_product", out_product, 0);
        check("rst_mul_start",   mul_start, 0);
        check("rst_operands",    {mul_multiplicand, mul_multiplier}, 0);
        check("rst_busy",        busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_jobs_done",   jobs_done, 0);
        check("rst_in_ready",    in_ready, 1);
        reset = 1'b0;
        @(negedge clock);

        // ---- 1: single job 13 x 11 ----
        s0 = start_count;
        push(4'd13, 4'd11);
        check("t1_in_ready", in_ready, 1);
        wait_results(1, "t1_count");
        check("t1_product",     results[0], 9'h08F);
        check("t1_start_lat",   start_cyc - push_cyc, 2);
        check("t1_result_lat",  res_cyc - done_cyc, 1);
        check("t1_jobs_done",   jobs_done, 1);
        repeat (5) @(negedge clock);
        check("t1_start_pulses", start_count - s0, 1);

        // ---- 2: back-to-back jobs ----
        wait_idle();
        results.delete();
        min_gap = 1000;
        push(4'd15, 4'd15);
        push(4'd0, 4'd9);
        push(4'd1, 4'd1);
        wait_results(3, "t2_count");
        check("t2_res0", results[0], 225);
        check("t2_res1", results[1], 0);
        check("t2_res2", results[2], 1);
        check("t2_job_gap", min_gap, 3);
        check("t2_jobs_done", jobs_done, 4);

        // ---- 3: result backpressure ----
        wait_idle();
        results.delete();
        out_ready = 1'b0;
        s0 = start_count;
        push(4'd2, 4'd3);
        push(4'd4, 4'd5);
        push(4'd7, 4'd7);
        push(4'd15, 4'd14);
        push(4'd9, 4'd12);
        repeat (20) @(negedge clock);
        check("t3_in_ready_full", in_ready, 0);
        check("t3_held_valid",    out_valid, 1);
        check("t3_held_product",  out_product, 6);
        check("t3_one_start",     start_count - s0, 1);
        check("t3_busy",          busy, 1);
        out_ready = 1'b1;
        wait_results(5, "t3_count");
        check("t3_res0", results[0], 6);
        check("t3_res1", results[1], 20);
        check("t3_res2", results[2], 49);
        check("t3_res3", results[3], 210);
        check("t3_res4", results[4], 108);
        check("t3_jobs_done", jobs_done, 9);

        // ---- 4: watchdog ----
        wait_idle();
        results.delete();
        model_en = 1'b0;
        push(4'd3, 4'd3);
        push(4'd2, 4'd2);
        n = 1;  // one edge already spent on the second push
        while (!timeout_err && n < 200) begin
            @(negedge clock);
            n++;
        end
        model_en = 1'b1;
        check("t4_timeout_err",   timeout_err, 1);
        check("t4_timeout_cycle", n, TIMEOUT + 2);
        check("t4_no_valid",      out_valid, 0);
        check("t4_jobs_same",     jobs_done, 9);
        wait_results(1, "t4_next_job");
        check("t4_next_product",  results[0], 4);
        check("t4_sticky",        timeout_err, 1);
        check("t4_jobs_done",     jobs_done, 10);

        // ---- 5: reset mid-job with two queued ----
        wait_idle();
        results.delete();
        push(4'd1, 4'd2);
        push(4'd3, 4'd4);
        push(4'd5, 4'd6);
        reset = 1'b1;
        #1;
        check("t5_out_valid",   out_valid, 0);
        check("t5_busy",        busy, 0);
        check("t5_in_ready",    in_ready, 1);
        check("t5_operands",    {mul_multiplicand, mul_multiplier}, 0);
        check("t5_jobs_done",   jobs_done, 0);
        check("t5_timeout_err", timeout_err, 0);
        check("t5_mul_start",   mul_start, 0);
        @(negedge clock);
        reset = 1'b0;
        s0 = start_count;
        repeat (20) @(negedge clock);
        check("t5_no_start",  start_count - s0, 0);
        check("t5_no_result", results.size(), 0);
        push(4'd6, 4'd7);
        wait_results(1, "t5_count");
        check("t5_product",    results[0], 42);
        check("t5_jobs_after", jobs_done, 1);

        // ---- 6: stray mul_done in idle ----
        wait_idle();
        results.delete();
        inj_product = 9'h1FF;
        inj_done    = 1'b1;
        @(negedge clock);
        inj_done = 1'b0;
        repeat (5) @(negedge clock);
        check("t6_out_valid", out_valid, 0);
        check("t6_jobs_done", jobs_done, 1);
        check("t6_no_result", results.size(), 0);

        check("operand_stability", operand_unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
